// File: rtl/shift_delay_line.sv
// shift_delay_line
//   Runtime-programmable delay line of 1..DEPTH enabled cycles, built on a
//   circular RAM buffer (asynchronous read, maps to distributed RAM) instead
//   of a flop chain. Tracks output validity and fill level, supports a
//   synchronous flush, and flags out-of-range delay requests.
//
// Parameters
//   WIDTH : data width in bits (1..64)
//   DEPTH : maximum delay in enabled cycles, power of two (2..1024)
//   AW    : width of delay / fill_level, $clog2(DEPTH)+1 (derived)
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset (priority over flush/enable)
//   enable     in   shift enable, one shift per enabled edge
//   flush      in   synchronous clear of pointer/fill/outputs (RAM untouched)
//   delay      in   requested delay, legal 1..DEPTH (clamped otherwise)
//   din        in   input sample, captured on enabled edges
//   dout       out  delayed sample, registered, 0 while not valid
//   dout_valid out  dout carries real data
//   fill_level out  samples written since reset/flush, saturates at DEPTH
//   cfg_err    out  sticky: an out-of-range delay was sampled on an enabled edge
module shift_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             flush,
  input  logic [AW-1:0]    delay,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [AW-1:0]    fill_level,
  output logic             cfg_err
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH);
  localparam logic [AW-1:0] ONE_AW   = AW'(1);

  // Clamp a requested delay into the legal range 1..DEPTH.
  function automatic logic [AW-1:0] clamp_delay(input logic [AW-1:0] d);
    logic [AW-1:0] r;
    r = d;
    if (d == '0)
      r = ONE_AW;
    else if (d > DEPTH_AW)
      r = DEPTH_AW;
    return r;
  endfunction

  // True when the requested delay lies outside 1..DEPTH.
  function automatic logic delay_out_of_range(input logic [AW-1:0] d);
    return (d == '0) || (d > DEPTH_AW);
  endfunction

  // Fill counter increment that sticks at DEPTH.
  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] f);
    logic [AW-1:0] r;
    r = f;
    if (f != DEPTH_AW)
      r = f + ONE_AW;
    return r;
  endfunction

  // Storage and control state
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [AW-1:0]    fill;

  // Combinational next-state
  logic [AW-1:0]    d_eff;
  logic             delay_bad;
  logic [PW-1:0]    rd_addr;
  logic [WIDTH-1:0] ram_rd;
  logic [AW-1:0]    fill_nxt;
  logic             vld_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             wr_en;

  // Stage p0: address generation and output selection for this edge.
  // The sample written at edge k-D+1 sits D-1 slots behind the slot that
  // edge k is about to write, so the read happens before that write lands.
  // With D = DEPTH this is the slot just ahead of wr_ptr, which is still
  // intact because the write of edge k has not occurred yet.
  always_comb begin
    d_eff     = clamp_delay(delay);
    delay_bad = delay_out_of_range(delay);
    rd_addr   = wr_ptr - PW'(d_eff - ONE_AW);
    ram_rd    = mem[rd_addr];
    fill_nxt  = sat_inc(fill);
    vld_nxt   = (fill_nxt >= d_eff);
    dout_nxt  = '0;
    if (vld_nxt) begin
      // D=1 is a plain register: the current sample goes straight out.
      if (d_eff == ONE_AW)
        dout_nxt = din;
      else
        dout_nxt = ram_rd;
    end
  end

  assign wr_en = reset_n && !flush && enable;

  // RAM write port; contents are deliberately never cleared so the array
  // stays a plain memory. Stale words are masked by the valid logic.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= din;
  end

  // Stage p1: registered pointer, fill counter and outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      fill       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      fill       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (enable) begin
      wr_ptr     <= wr_ptr + PW'(1);
      fill       <= fill_nxt;
      dout       <= dout_nxt;
      dout_valid <= vld_nxt;
      cfg_err    <= cfg_err | delay_bad;
    end
  end

  assign fill_level = fill;

endmodule

// File: tb/tb_shift_delay_line.sv
// Testbench for shift_delay_line (WIDTH=8, DEPTH=16): table-driven priming
// vectors, hand-written corner sequences, and a long randomized run, all
// checked through an expectation queue fed by a reference history model.
module tb_shift_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             flush;
  logic [AW-1:0]    delay;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [AW-1:0]    fill_level;
  logic             cfg_err;

  always #5 clk = ~clk;

  shift_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .flush      (flush),
    .delay      (delay),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .fill_level (fill_level),
    .cfg_err    (cfg_err)
  );

  typedef struct {
    logic             en;
    logic             fl;
    logic [AW-1:0]    dly;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e_dout;
    logic             e_vld;
    logic [AW-1:0]    e_fill;
    logic             e_err;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] dout;
    logic             vld;
    logic [AW-1:0]    fill;
    logic             err;
    string            tag;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: history of samples since reset/flush.
  logic [WIDTH-1:0] hist[$];
  int               m_k    = 0;
  int               m_fill = 0;
  logic             m_vld  = 1'b0;
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_err  = 1'b0;

  task automatic model_edge(input logic rstn, input logic en, input logic fl,
                            input logic [AW-1:0] dly, input logic [WIDTH-1:0] d);
    int dd;
    if (!rstn || fl) begin
      m_k = 0; hist.delete(); m_dout = '0; m_vld = 1'b0; m_fill = 0; m_err = 1'b0;
    end else if (en) begin
      dd = int'(dly);
      if (dd == 0) begin dd = 1; m_err = 1'b1; end
      else if (dd > DEPTH) begin dd = DEPTH; m_err = 1'b1; end
      hist.push_back(d);
      m_k++;
      m_fill = (m_k > DEPTH) ? DEPTH : m_k;
      m_vld  = (m_fill >= dd);
      m_dout = m_vld ? hist[hist.size() - dd] : '0;
      if (hist.size() > 2 * DEPTH) void'(hist.pop_front());
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic clock_and_compare();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "/dout"},       32'(dout),       32'(e.dout));
      check({e.tag, "/dout_valid"}, 32'(dout_valid), 32'(e.vld));
      check({e.tag, "/fill_level"}, 32'(fill_level), 32'(e.fill));
      check({e.tag, "/cfg_err"},    32'(cfg_err),    32'(e.err));
    end
  endtask

  // Drive one cycle; expectation comes from the reference model.
  task automatic drive(input logic rstn, input logic en, input logic fl,
                       input logic [AW-1:0] dly, input logic [WIDTH-1:0] d, input string tag);
    exp_t e;
    reset_n = rstn; enable = en; flush = fl; delay = dly; din = d;
    model_edge(rstn, en, fl, dly, d);
    e.dout = m_dout; e.vld = m_vld; e.fill = AW'(m_fill); e.err = m_err; e.tag = tag;
    exp_q.push_back(e);
    clock_and_compare();
  endtask

  // Drive one cycle; expectation comes from the vector table.
  task automatic apply_vec(input vec_t v, input string tag);
    exp_t e;
    reset_n = 1'b1; enable = v.en; flush = v.fl; delay = v.dly; din = v.d;
    model_edge(1'b1, v.en, v.fl, v.dly, v.d);
    e.dout = v.e_dout; e.vld = v.e_vld; e.fill = v.e_fill; e.err = v.e_err; e.tag = tag;
    exp_q.push_back(e);
    clock_and_compare();
  endtask

  function automatic vec_t mk(input logic en, input logic fl, input int dly, input int d,
                              input int edout, input logic evld, input int efill, input logic eerr);
    vec_t v;
    v.en = en; v.fl = fl; v.dly = AW'(dly); v.d = WIDTH'(d);
    v.e_dout = WIDTH'(edout); v.e_vld = evld; v.e_fill = AW'(efill); v.e_err = eerr;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0]    cur_dly;
    logic [WIDTH-1:0] rd;

    // Priming table: delay=4, din=k on enabled edge k, with an enable gap.
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(1, 0, 4, k, (k >= 4) ? k - 3 : 0, k >= 4, k, 0));
    for (int g = 0; g < 3; g++)
      tbl.push_back(mk(0, 0, 4, 8'hEE, 7, 1, 10, 0));
    for (int k = 11; k <= 20; k++)
      tbl.push_back(mk(1, 0, 4, k, k - 3, 1, (k > DEPTH) ? DEPTH : k, 0));
    tbl.push_back(mk(1, 0, 16, 21, 6, 1, 16, 0));
    tbl.push_back(mk(1, 0, 1, 22, 22, 1, 16, 0));

    reset_n = 1'b0; enable = 1'b0; flush = 1'b0; delay = AW'(4); din = '0;

    drive(0, 0, 0, 4, 8'h00, "reset");
    drive(0, 1, 1, 4, 8'h33, "reset_prio");

    for (int i = 0; i < tbl.size(); i++)
      apply_vec(tbl[i], $sformatf("prime%0d", i));

    // Range errors from a full buffer.
    drive(1, 1, 0, 0, 8'h5A, "dly0");
    check("dly0_passthru", 32'(dout), 32'h5A);
    check("dly0_err", 32'(cfg_err), 32'h1);
    drive(1, 1, 0, 20, 8'h10, "dly20");
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 4, WIDTH'(8'h20 + i), "dly4_after_err");
    check("err_sticky", 32'(cfg_err), 32'h1);
    drive(1, 0, 0, 0, 8'h77, "dly0_disabled");

    // Flush at edge 12 after a fresh start, with cfg_err set on the way.
    drive(0, 0, 0, 4, 8'h00, "reset2");
    for (int k = 1; k <= 11; k++) drive(1, 1, 0, (k == 5) ? 20 : 4, WIDTH'(k), "pre_flush");
    drive(1, 1, 1, 2, 8'hAA, "flush");
    check("flush_dout", 32'(dout), 32'h0);
    check("flush_vld", 32'(dout_valid), 32'h0);
    check("flush_fill", 32'(fill_level), 32'h0);
    check("flush_err", 32'(cfg_err), 32'h0);
    drive(1, 1, 0, 2, 8'h55, "post_flush1");
    drive(1, 1, 0, 2, 8'h66, "post_flush2");
    check("post_flush_dout", 32'(dout), 32'h55);
    check("post_flush_vld", 32'(dout_valid), 32'h1);
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 16, WIDTH'(i), "post_flush_d16");

    // Reset mid-stream, then replay priming.
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 4, WIDTH'($urandom_range(0, 255)), "steady");
    drive(0, 1, 0, 4, 8'h99, "mid_reset");
    check("mid_reset_dout", 32'(dout), 32'h0);
    check("mid_reset_vld", 32'(dout_valid), 32'h0);
    check("mid_reset_fill", 32'(fill_level), 32'h0);
    for (int i = 0; i < 10; i++)
      apply_vec(tbl[i], $sformatf("recover%0d", i));

    // Randomized run against the reference model.
    cur_dly = AW'(4);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 63) == 0) cur_dly = AW'($urandom_range(0, 20));
      rd = WIDTH'($urandom_range(0, 255));
      drive(($urandom_range(0, 1999) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 499) == 0), cur_dly, rd, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
